// File: rtl/mfc_ram_slave.sv
// Clocked memory slave for the CPU enable/rw/mfc handshake.
// Read and write wait states are programmable, and addresses at or above DEPTH report err.
module mfc_ram_slave #(
    parameter int unsigned DATA_W     = 16,
    parameter int unsigned ADDR_W     = 16,
    parameter int unsigned DEPTH      = 65536,
    parameter int unsigned READ_WAIT  = 3,
    parameter int unsigned WRITE_WAIT = 3
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              enable,
    input  logic              rw,
    input  logic [ADDR_W-1:0] address,
    input  logic [DATA_W-1:0] data_in,
    output logic [DATA_W-1:0] data_out,
    output logic              mfc,
    output logic              err,
    output logic              busy
);

    localparam int unsigned CNT_W = 8;
    localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    generate
        if (READ_WAIT > 255 || WRITE_WAIT > 255) begin : g_bad_wait
            $error("mfc_ram_slave: READ_WAIT/WRITE_WAIT must be 0..255");
        end
        if (DEPTH < 1 || IDX_W > ADDR_W) begin : g_bad_depth
            $error("mfc_ram_slave: DEPTH must be 1..2**ADDR_W");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_e;

    state_e              state_q, state_d;
    logic                rw_q, rw_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                mfc_q, mfc_d;
    logic                err_q, err_d;
    logic [DATA_W-1:0]   dout_q, dout_d;
    logic                busy_q, busy_d;

    logic [DATA_W-1:0]   mem [DEPTH];
    logic                mapped_c;
    logic [IDX_W-1:0]    idx_c;
    logic                we_c;

    assign mapped_c = (32'(addr_q) < DEPTH);
    assign idx_c    = addr_q[IDX_W-1:0];

    // Next-state and registered-output logic.
    always_comb begin
        state_d = state_q;
        rw_d    = rw_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        cnt_d   = cnt_q;
        mfc_d   = mfc_q;
        err_d   = err_q;
        dout_d  = dout_q;
        we_c    = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (enable) begin
                    rw_d    = rw;
                    addr_d  = address;
                    wdata_d = data_in;
                    cnt_d   = rw ? CNT_W'(WRITE_WAIT) : CNT_W'(READ_WAIT);
                    state_d = S_BUSY;
                end
            end
            S_BUSY: begin
                if (!enable) begin
                    state_d = S_IDLE;
                end else if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else begin
                    mfc_d   = 1'b1;
                    err_d   = !mapped_c;
                    state_d = S_DONE;
                    if (rw_q) begin
                        we_c = mapped_c;
                    end else begin
                        dout_d = mapped_c ? mem[idx_c] : '0;
                    end
                end
            end
            S_DONE: begin
                if (!enable) begin
                    mfc_d   = 1'b0;
                    err_d   = 1'b0;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            rw_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            cnt_q   <= '0;
            mfc_q   <= 1'b0;
            err_q   <= 1'b0;
            dout_q  <= '0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            rw_q    <= rw_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            cnt_q   <= cnt_d;
            mfc_q   <= mfc_d;
            err_q   <= err_d;
            dout_q  <= dout_d;
            busy_q  <= busy_d;
        end
    end

    // RAM array keeps its contents across reset.
    always_ff @(posedge clock) begin
        if (we_c) begin
            mem[idx_c] <= wdata_q;
        end
    end

    assign data_out = dout_q;
    assign mfc      = mfc_q;
    assign err      = err_q;
    assign busy     = busy_q;

endmodule

// File: tb/tb_mfc_ram_slave.sv
// Bench for mfc_ram_slave: two instances (full 64K map, and 1K map) driven by
// directed vectors, hand sequences for abort/reset, and random traffic against a model.
module tb_mfc_ram_slave;

    localparam int unsigned DEP0 = 65536;
    localparam int unsigned RW0  = 3;
    localparam int unsigned WW0  = 0;
    localparam int unsigned DEP1 = 1024;
    localparam int unsigned RW1  = 3;
    localparam int unsigned WW1  = 2;

    logic        clock = 1'b0;
    logic        rst_n = 1'b0;
    logic [1:0]  en    = '0;
    logic [1:0]  rwv   = '0;
    logic [15:0] ad [2];
    logic [15:0] di [2];
    logic [15:0] dout [2];
    logic [1:0]  mfc;
    logic [1:0]  err;
    logic [1:0]  busy;

    int checks = 0;
    int errors = 0;

    logic [15:0] mdl [2][65536];
    bit          kn  [2][65536];
    logic [15:0] expd [2];

    always #5 clock = ~clock;

    mfc_ram_slave #(.DATA_W(16), .ADDR_W(16), .DEPTH(DEP0), .READ_WAIT(RW0), .WRITE_WAIT(WW0)) u_dut0 (
        .clock(clock), .reset(rst_n), .enable(en[0]), .rw(rwv[0]), .address(ad[0]),
        .data_in(di[0]), .data_out(dout[0]), .mfc(mfc[0]), .err(err[0]), .busy(busy[0])
    );

    mfc_ram_slave #(.DATA_W(16), .ADDR_W(16), .DEPTH(DEP1), .READ_WAIT(RW1), .WRITE_WAIT(WW1)) u_dut1 (
        .clock(clock), .reset(rst_n), .enable(en[1]), .rw(rwv[1]), .address(ad[1]),
        .data_in(di[1]), .data_out(dout[1]), .mfc(mfc[1]), .err(err[1]), .busy(busy[1])
    );

    typedef struct {
        int          d;
        logic        w;
        logic [15:0] a;
        logic [15:0] wd;
        int          hold;
        logic [15:0] ed;
        logic        ee;
        int          el;
    } vec_t;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    function automatic int unsigned depth_of(input int d);
        return (d == 0) ? DEP0 : DEP1;
    endfunction

    function automatic int unsigned lat_of(input int d, input logic w);
        if (d == 0) return (w ? WW0 : RW0) + 1;
        return (w ? WW1 : RW1) + 1;
    endfunction

    // One complete request; called at a negedge with enable low, returns at a negedge with enable low.
    task automatic run_access(input int d, input logic w, input logic [15:0] a, input logic [15:0] wd,
                              input int hold, input logic [15:0] ed, input logic ee, input int el);
        int n;
        en[d] = 1'b1; rwv[d] = w; ad[d] = a; di[d] = wd;
        @(posedge clock); #1;
        rwv[d] = ~w; ad[d] = ~a; di[d] = ~wd;
        n = 0;
        @(negedge clock);
        chk($sformatf("busy_after_accept d%0d", d), 32'(busy[d]), 32'd1);
        while (!mfc[d] && n < 300) begin
            @(posedge clock); n++;
            @(negedge clock);
        end
        chk($sformatf("latency d%0d a%0h", d, a), 32'(n), 32'(el));
        chk($sformatf("mfc d%0d", d), 32'(mfc[d]), 32'd1);
        chk($sformatf("err d%0d a%0h", d, a), 32'(err[d]), 32'(ee));
        chk($sformatf("data_out d%0d a%0h", d, a), 32'(dout[d]), 32'(ed));
        for (int i = 0; i < hold; i++) begin
            @(negedge clock);
            chk($sformatf("mfc_hold d%0d", d), {15'd0, mfc[d], dout[d]}, {15'd0, 1'b1, ed});
        end
        en[d] = 1'b0;
        @(negedge clock);
        chk($sformatf("release d%0d", d), {13'd0, mfc[d], err[d], busy[d], dout[d]}, {16'd0, ed});
    endtask

    task automatic model_update(input int d, input logic w, input logic [15:0] a,
                                input logic [15:0] wd, input logic [15:0] ed);
        if (w) begin
            if (32'(a) < depth_of(d)) begin
                mdl[d][a] = wd;
                kn[d][a]  = 1'b1;
            end
        end else begin
            expd[d] = ed;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired t=%0t", $time);
        $fatal(1, "timeout");
    end

    initial begin
        vec_t vecs [10];
        ad[0] = '0; ad[1] = '0; di[0] = '0; di[1] = '0;
        expd[0] = '0; expd[1] = '0;

        vecs[0] = '{0, 1'b1, 16'h0005, 16'h001B, 0,  16'h0000, 1'b0, 1};
        vecs[1] = '{0, 1'b0, 16'h0005, 16'h0000, 0,  16'h001B, 1'b0, 4};
        vecs[2] = '{0, 1'b1, 16'hFFEB, 16'hFFEB, 0,  16'h001B, 1'b0, 1};
        vecs[3] = '{0, 1'b0, 16'hFFEB, 16'h0000, 0,  16'hFFEB, 1'b0, 4};
        vecs[4] = '{1, 1'b1, 16'h0000, 16'h1234, 0,  16'h0000, 1'b0, 3};
        vecs[5] = '{1, 1'b0, 16'h0400, 16'h0000, 0,  16'h0000, 1'b1, 4};
        vecs[6] = '{1, 1'b1, 16'h0400, 16'hBEEF, 0,  16'h0000, 1'b1, 3};
        vecs[7] = '{1, 1'b0, 16'h0000, 16'h0000, 0,  16'h1234, 1'b0, 4};
        vecs[8] = '{0, 1'b1, 16'h0007, 16'h5555, 10, 16'hFFEB, 1'b0, 1};
        vecs[9] = '{0, 1'b0, 16'h0007, 16'h0000, 0,  16'h5555, 1'b0, 4};

        #3;
        for (int d = 0; d < 2; d++)
            chk($sformatf("reset_outputs d%0d", d), {13'd0, mfc[d], err[d], busy[d], dout[d]}, 32'd0);
        repeat (2) @(negedge clock);
        rst_n = 1'b1;
        @(negedge clock);

        for (int i = 0; i < 10; i++) begin
            run_access(vecs[i].d, vecs[i].w, vecs[i].a, vecs[i].wd, vecs[i].hold,
                       vecs[i].ed, vecs[i].ee, vecs[i].el);
            model_update(vecs[i].d, vecs[i].w, vecs[i].a, vecs[i].wd, vecs[i].ed);
        end

        // Abort: write of AAAA to address 7 dropped while BUSY.
        en[0] = 1'b1; rwv[0] = 1'b1; ad[0] = 16'h0007; di[0] = 16'hAAAA;
        @(posedge clock); #1;
        en[0] = 1'b0;
        @(negedge clock);
        chk("abort_busy", {30'd0, busy[0], mfc[0]}, 32'd2);
        @(negedge clock);
        chk("abort_idle", {30'd0, busy[0], mfc[0]}, 32'd0);
        repeat (3) @(negedge clock);
        chk("abort_no_mfc", 32'(mfc[0]), 32'd0);
        run_access(0, 1'b0, 16'h0007, 16'h0000, 0, 16'h5555, 1'b0, 4);

        // Reset while a write is in BUSY on the 1K instance.
        en[1] = 1'b1; rwv[1] = 1'b1; ad[1] = 16'h0000; di[1] = 16'h9999;
        @(posedge clock); #1;
        @(negedge clock);
        chk("rst_pre_busy", 32'(busy[1]), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_async_outputs", {13'd0, mfc[1], err[1], busy[1], dout[1]}, 32'd0);
        chk("rst_async_dout0", 32'(dout[0]), 32'd0);
        en[1] = 1'b0;
        @(negedge clock);
        @(negedge clock);
        rst_n = 1'b1;
        expd[0] = '0; expd[1] = '0;
        @(negedge clock);
        run_access(1, 1'b0, 16'h0000, 16'h0000, 0, 16'h1234, 1'b0, 4);
        expd[1] = 16'h1234;

        // Random traffic against the model.
        for (int i = 0; i < 60; i++) begin
            int d;
            logic w;
            logic [15:0] a;
            logic [15:0] wd;
            logic [15:0] ed;
            logic mp;
            int hold;
            d  = int'($urandom_range(0, 1));
            w  = 1'($urandom_range(0, 1));
            a  = 16'($urandom_range(0, 31));
            if (d == 1 && $urandom_range(0, 3) == 0) a = a + 16'h0400;
            if (d == 0 && $urandom_range(0, 3) == 0) a = a | 16'hFFE0;
            mp = (32'(a) < depth_of(d));
            if (!w && mp && !kn[d][a]) w = 1'b1;
            wd   = 16'($urandom);
            hold = int'($urandom_range(0, 3));
            ed   = w ? expd[d] : (mp ? mdl[d][a] : 16'h0000);
            run_access(d, w, a, wd, hold, ed, !mp, int'(lat_of(d, w)));
            model_update(d, w, a, wd, ed);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
